// File: rtl/fifo_uart_tx_if.sv
// Bundle between the byte FIFO read side / status pins and the UART drain stage.
// The FIFO side (master) presents data and empty flag; fifo_uart_tx (slave) pops and reports status.
interface fifo_uart_tx_if #(
   parameter int CNT_W = 8
);
   logic             en;
   logic [7:0]       fifo_data;
   logic             fifo_empty;
   logic             fifo_rd;
   logic             tx;
   logic             busy;
   logic [CNT_W-1:0] frames_sent;

   modport master (
      output en, fifo_data, fifo_empty,
      input  fifo_rd, tx, busy, frames_sent
   );

   modport slave (
      input  en, fifo_data, fifo_empty,
      output fifo_rd, tx, busy, frames_sent
   );
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops first-word-fall-through bytes and sends each as an 8N1 UART frame.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int CNT_W        = 8
) (
   input logic            clk,
   input logic            rst_n,
   fifo_uart_tx_if.slave  bus
);
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam logic [2:0] S_PARITY = 3'd3;
`endif
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [2:0]        state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              tx_q, tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
   logic              par_q, par_d;
`endif
   logic              baud_last;
   logic              fifo_rd;

   assign baud_last = (baud_q == BAUD_LAST);

   // NOTE: the strobe is gated by rst_n so the FIFO never pops while this block is held in reset.
   assign fifo_rd = rst_n & bus.en & ~bus.fifo_empty &
                    ((state_q == S_IDLE) | ((state_q == S_STOP) & baud_last));

   always_comb begin
      // NOTE: every next-state signal gets a default first, so no path can infer a latch.
      state_d = state_q;
      baud_d  = baud_last ? '0 : baud_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
`ifdef FIFO_UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         S_IDLE: begin
            baud_d = '0;
            if (fifo_rd) begin
               shift_d = bus.fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
               par_d   = ^bus.fifo_data;
`endif
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_last) begin
               bit_d   = 3'd0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_last) begin
               shift_d = shift_q >> 1;
               if (bit_q == 3'd7) begin
`ifdef FIFO_UART_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         S_PARITY: begin
            if (baud_last) state_d = S_STOP;
         end
`endif
         S_STOP: begin
            if (baud_last) begin
               cnt_d = cnt_q + 1'b1;
               // Back-to-back: reload straight into START with no idle gap.
               if (fifo_rd) begin
                  shift_d = bus.fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
                  par_d   = ^bus.fifo_data;
`endif
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // The line level is derived from the next state so tx can come straight from a flop.
      tx_d = 1'b1;
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
         S_PARITY: tx_d = par_d;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         cnt_q   <= '0;
         tx_q    <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         tx_q    <= tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign bus.fifo_rd     = fifo_rd;
   assign bus.tx          = tx_q;
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.frames_sent = cnt_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised bench for fifo_uart_tx: a queue-based FIFO plus a frame-level model of the serial line.
// Define FIFO_UART_TX_PARITY_EN for both RTL and bench to check the parity build.
module tb_fifo_uart_tx;
   localparam int CPB   = 4;
   localparam int CNT_W = 4;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME_LEN = FRAME_BITS * CPB;

   typedef struct packed {
      logic lvl;
      logic last;
   } slot_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   fifo_uart_tx_if #(.CNT_W(CNT_W)) bus ();

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int busy_cycles = 0;
   int pops = 0;

   logic             rst_v = 1'b0;
   logic             en_v = 1'b1;
   logic             hold_v = 1'b0;
   logic [CNT_W-1:0] model_cnt = '0;
   logic [7:0]       fifo_q[$];
   slot_t            exp_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   // Expected line levels for one frame, one entry per clock cycle.
   task automatic push_frame(input logic [7:0] b);
      logic [FRAME_BITS-1:0] bits;
`ifdef FIFO_UART_TX_PARITY_EN
      bits = {1'b1, ^b, b, 1'b0};
`else
      bits = {1'b1, b, 1'b0};
`endif
      for (int i = 0; i < FRAME_BITS; i++)
         for (int c = 0; c < CPB; c++)
            exp_q.push_back('{lvl: bits[i], last: (i == FRAME_BITS - 1) && (c == CPB - 1)});
   endtask

   task automatic step();
      slot_t s;
      logic  exp_tx, exp_busy, exp_rd, last, avail;
      logic [7:0] b;
      @(negedge clk);
      exp_tx = 1'b1;
      exp_busy = 1'b0;
      last = 1'b0;
      if (exp_q.size() > 0) begin
         s = exp_q.pop_front();
         exp_tx = s.lvl;
         exp_busy = 1'b1;
         last = s.last;
      end
      chk("tx", 32'(bus.tx), 32'(exp_tx));
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      chk("frames_sent", 32'(bus.frames_sent), 32'(model_cnt));
      if (bus.busy) busy_cycles++;
      if (last) model_cnt = model_cnt + 1'b1;

      rst_n = rst_v;
      bus.en = en_v;
      avail = (fifo_q.size() > 0) && !hold_v;
      bus.fifo_empty = !avail;
      bus.fifo_data = avail ? fifo_q[0] : 8'($urandom);
      #1;
      // A pop is due whenever the line has nothing left to send and a byte is offered.
      exp_rd = rst_v && en_v && avail && (exp_q.size() == 0);
      chk("fifo_rd", 32'(bus.fifo_rd), 32'(exp_rd));
      if (bus.fifo_rd && avail) begin
         b = fifo_q.pop_front();
         push_frame(b);
         pops++;
      end
      if (!rst_v) begin
         exp_q.delete();
         model_cnt = '0;
      end
   endtask

   task automatic run_idle(input int budget);
      int n = 0;
      logic timed_out;
      while ((exp_q.size() > 0 || (fifo_q.size() > 0 && en_v && !hold_v)) && n < budget) begin
         step();
         n++;
      end
      step();
      timed_out = (n >= budget);
      chk("drain_done", 32'(timed_out), 32'd0);
   endtask

   initial begin
      int start_pops;
      bus.en = 1'b1;
      bus.fifo_empty = 1'b1;
      bus.fifo_data = 8'h00;

      // Reset with a byte already offered: nothing may pop.
      fifo_q.push_back(8'hA5);
      rst_v = 1'b0;
      en_v = 1'b1;
      repeat (3) step();
      chk("reset_no_pop", 32'(pops), 32'd0);

      // Single byte 0xA5.
      rst_v = 1'b1;
      busy_cycles = 0;
      repeat (FRAME_LEN + 6) step();
      chk("a5_busy_cycles", 32'(busy_cycles), 32'(FRAME_LEN));
      chk("a5_frames", 32'(bus.frames_sent), 32'd1);

      // Back-to-back 0x00, 0xFF.
      fifo_q.push_back(8'h00);
      fifo_q.push_back(8'hFF);
      busy_cycles = 0;
      repeat (2 * FRAME_LEN + 6) step();
      chk("b2b_busy_cycles", 32'(busy_cycles), 32'(2 * FRAME_LEN));
      chk("b2b_frames", 32'(bus.frames_sent), 32'd3);

      // en low with data waiting, then drop en mid-frame.
      en_v = 1'b0;
      fifo_q.push_back(8'h3C);
      start_pops = pops;
      repeat (20) step();
      chk("en_low_pops", 32'(pops - start_pops), 32'd0);
      en_v = 1'b1;
      repeat (CPB * 4 + 1) step();
      en_v = 1'b0;
      fifo_q.push_back(8'h5A);
      repeat (FRAME_LEN + 10) step();
      chk("en_drop_pops", 32'(pops - start_pops), 32'd1);
      chk("en_drop_left", 32'(fifo_q.size()), 32'd1);
      en_v = 1'b1;
      run_idle(4 * FRAME_LEN);

      // Reset during DATA bit 3, then a normal frame afterwards.
      fifo_q.push_back(8'hC3);
      repeat (1 + CPB + 3 * CPB + 1) step();
      rst_v = 1'b0;
      step();
      rst_v = 1'b1;
      fifo_q.push_back(8'h96);
      step();
      chk("rst_mid_frames", 32'(bus.frames_sent), 32'd0);
      run_idle(4 * FRAME_LEN);
      chk("rst_after_frames", 32'(bus.frames_sent), 32'd1);

`ifdef FIFO_UART_TX_PARITY_EN
      fifo_q.push_back(8'h07);
      fifo_q.push_back(8'h03);
      run_idle(4 * FRAME_LEN);
`endif

      // Randomised traffic: bursts of bytes, FIFO stalls, en toggling, rare resets.
      for (int it = 0; it < 60; it++) begin
         int nb = $urandom_range(0, 3);
         for (int k = 0; k < nb; k++) fifo_q.push_back(8'($urandom));
         hold_v = ($urandom_range(0, 3) == 0);
         en_v = ($urandom_range(0, 4) != 0);
         rst_v = ($urandom_range(0, 29) != 0);
         step();
         rst_v = 1'b1;
         repeat ($urandom_range(1, 2 * FRAME_LEN)) step();
      end
      hold_v = 1'b0;
      en_v = 1'b1;
      rst_v = 1'b1;
      run_idle(200 * FRAME_LEN);

      // Counter wrap: more than 2^CNT_W frames in one stream.
      for (int k = 0; k < (1 << CNT_W) + 3; k++) fifo_q.push_back(8'($urandom));
      run_idle(((1 << CNT_W) + 6) * FRAME_LEN);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
